// File: rtl/lcd_seq_pkg.sv
// Shared types and constants for the LCD page sequencer.
// Optional build macro: LCD_CURSOR_MARK_EN (cursor glyph on menu line 1).
package lcd_seq_pkg;

    localparam int         LINE_LEN  = 16;
    localparam int         IDX_W     = 4;
    localparam logic [7:0] LINE0_CMD = 8'h80;
    localparam logic [7:0] LINE1_CMD = 8'hC0;
    localparam logic [7:0] MARK_CHAR = 8'h7E;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WAIT,
        SEND,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        PAGE_MENU   = 2'd0,
        PAGE_REMOTE = 2'd1,
        PAGE_LOCAL  = 2'd2,
        PAGE_RSVD   = 2'd3
    } page_t;

    function automatic logic [7:0] lineCmd(input logic line);
        return line ? LINE1_CMD : LINE0_CMD;
    endfunction

endpackage

// File: rtl/lcd_seq_addr_gen.sv
// Maps the current page/line/char position onto the shared RAM read port.
// Combinational; the top registers the result when entering ADDR.
module lcd_seq_addr_gen
    import lcd_seq_pkg::*;
(
    input  page_t       page,
    input  logic        line,
    input  logic [3:0]  idx,
    input  logic [3:0]  menuLine0,
    input  logic [3:0]  menuLine1,
    output logic [1:0]  ramSel,
    output logic [4:0]  ramAdd,
    output logic [3:0]  ramMenu
);

    always_comb begin
        ramSel  = page;
        ramAdd  = {line, idx};
        ramMenu = 4'd0;
        unique case (page)
            PAGE_MENU: begin
                ramAdd  = {1'b0, idx};
                ramMenu = line ? menuLine1 : menuLine0;
            end
            PAGE_REMOTE,
            PAGE_LOCAL,
            PAGE_RSVD: begin
                ramAdd  = {line, idx};
                ramMenu = 4'd0;
            end
            default: begin
                ramAdd  = {line, idx};
                ramMenu = 4'd0;
            end
        endcase
    end

endmodule

// File: rtl/lcd_page_sequencer.sv
// Reads one 2x16 LCD page through the shared RAM port and streams it to the LCD writer.
// Optional build macro: LCD_CURSOR_MARK_EN.
module lcd_page_sequencer
    import lcd_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] page_sel,
    input  logic [3:0] menu_line0,
    input  logic [3:0] menu_line1,
    output logic [1:0] ram_sel,
    output logic [3:0] ram_menu,
    output logic [4:0] ram_add,
    input  logic [7:0] ram_dout,
    output logic       lcd_valid,
    output logic       lcd_is_cmd,
    output logic [7:0] lcd_data,
    input  logic       lcd_ready,
    output logic       busy,
    output logic       done
);

    state_t     state;
    page_t      page;
    logic       line;
    logic [3:0] idx;
    logic [3:0] menu0Q;
    logic [3:0] menu1Q;
    logic [3:0] nextIdx;
    logic [1:0] genSel;
    logic [4:0] genAdd;
    logic [3:0] genMenu;
    logic [7:0] charIn;

    // Address is computed for the position the next ADDR state will read.
    assign nextIdx = (state == CMD) ? 4'd0 : idx + 4'd1;

    lcd_seq_addr_gen addrGen (
        .page      (page),
        .line      (line),
        .idx       (nextIdx),
        .menuLine0 (menu0Q),
        .menuLine1 (menu1Q),
        .ramSel    (genSel),
        .ramAdd    (genAdd),
        .ramMenu   (genMenu)
    );

`ifdef LCD_CURSOR_MARK_EN
    assign charIn = (page == PAGE_MENU && line && idx == 4'd0) ? MARK_CHAR : ram_dout;
`else
    assign charIn = ram_dout;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            page       <= PAGE_MENU;
            line       <= 1'b0;
            idx        <= 4'd0;
            menu0Q     <= 4'd0;
            menu1Q     <= 4'd0;
            ram_sel    <= 2'd0;
            ram_add    <= 5'd0;
            ram_menu   <= 4'd0;
            lcd_valid  <= 1'b0;
            lcd_is_cmd <= 1'b0;
            lcd_data   <= 8'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && page_sel != PAGE_RSVD) begin
                        page       <= page_t'(page_sel);
                        menu0Q     <= menu_line0;
                        menu1Q     <= menu_line1;
                        line       <= 1'b0;
                        idx        <= 4'd0;
                        busy       <= 1'b1;
                        lcd_valid  <= 1'b1;
                        lcd_is_cmd <= 1'b1;
                        lcd_data   <= lineCmd(1'b0);
                        state      <= CMD;
                    end
                end
                CMD: begin
                    if (lcd_ready) begin
                        idx       <= 4'd0;
                        lcd_valid <= 1'b0;
                        ram_sel   <= genSel;
                        ram_add   <= genAdd;
                        ram_menu  <= genMenu;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    state <= WAIT;
                end
                WAIT: begin
                    lcd_valid  <= 1'b1;
                    lcd_is_cmd <= 1'b0;
                    lcd_data   <= charIn;
                    state      <= SEND;
                end
                SEND: begin
                    if (lcd_ready) begin
                        lcd_valid <= 1'b0;
                        if (idx != LAST_IDX) begin
                            idx      <= nextIdx;
                            ram_sel  <= genSel;
                            ram_add  <= genAdd;
                            ram_menu <= genMenu;
                            state    <= ADDR;
                        end else if (!line) begin
                            line       <= 1'b1;
                            lcd_valid  <= 1'b1;
                            lcd_is_cmd <= 1'b1;
                            lcd_data   <= lineCmd(1'b1);
                            state      <= CMD;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_page_sequencer.sv
// Directed bench for lcd_page_sequencer with a RAM/ROM model and stream monitor.
// Build with or without LCD_CURSOR_MARK_EN.
module tb_lcd_page_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] page_sel;
    logic [3:0] menu_line0;
    logic [3:0] menu_line1;
    logic [1:0] ram_sel;
    logic [3:0] ram_menu;
    logic [4:0] ram_add;
    logic [7:0] ram_dout;
    logic       lcd_valid;
    logic       lcd_is_cmd;
    logic [7:0] lcd_data;
    logic       lcd_ready;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lcd_page_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .page_sel   (page_sel),
        .menu_line0 (menu_line0),
        .menu_line1 (menu_line1),
        .ram_sel    (ram_sel),
        .ram_menu   (ram_menu),
        .ram_add    (ram_add),
        .ram_dout   (ram_dout),
        .lcd_valid  (lcd_valid),
        .lcd_is_cmd (lcd_is_cmd),
        .lcd_data   (lcd_data),
        .lcd_ready  (lcd_ready),
        .busy       (busy),
        .done       (done)
    );

    // "MAIN MENU" and " Yes" menu ROM entries, FE padded
    logic [7:0] romMain [16] = '{8'h4D, 8'h41, 8'h49, 8'h4E, 8'h20, 8'h4D, 8'h45, 8'h4E,
                                 8'h55, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE};
    logic [7:0] romYes  [16] = '{8'hFE, 8'h59, 8'h65, 8'h73, 8'hFE, 8'hFE, 8'hFE, 8'hFE,
                                 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE};

    function automatic logic [7:0] romByte(input logic [3:0] entry, input logic [3:0] i);
        if (entry == 4'd0) return romMain[i];
        if (entry == 4'd8) return romYes[i];
        return {4'h3, i};
    endfunction

    always @(posedge clk) begin
        case (ram_sel)
            2'd0:    ram_dout <= romByte(ram_menu, ram_add[3:0]);
            2'd1:    ram_dout <= 8'hA0 + {3'b000, ram_add};
            2'd2:    ram_dout <= 8'h40 + {3'b000, ram_add};
            default: ram_dout <= 8'h00;
        endcase
    end

    logic [8:0] gotQ [$];
    logic [8:0] expQ [$];
    int   doneCount;
    int   busyCycles;
    int   stallErrs;
    int   add4Errs;
    logic prevValid, prevReady, prevCmd;
    logic [7:0] prevData;

    always @(negedge clk) begin
        if (rst) begin
            prevValid = 1'b0;
        end else begin
            if (prevValid && !prevReady &&
                (lcd_valid !== 1'b1 || lcd_is_cmd !== prevCmd || lcd_data !== prevData))
                stallErrs++;
            if (lcd_valid && lcd_ready) gotQ.push_back({lcd_is_cmd, lcd_data});
            if (done) doneCount++;
            if (busy) busyCycles++;
            if (busy && ram_sel == 2'd0 && ram_add[4]) add4Errs++;
            prevValid = lcd_valid;
            prevReady = lcd_ready;
            prevCmd   = lcd_is_cmd;
            prevData  = lcd_data;
        end
    end

    task automatic clear_obs();
        gotQ.delete();
        doneCount  = 0;
        busyCycles = 0;
        stallErrs  = 0;
        add4Errs   = 0;
    endtask

    task automatic do_start(input logic [1:0] sel);
        @(posedge clk); #1;
        page_sel = sel;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit toggle);
        int cyc = 0;
        while (doneCount == 0 && cyc < budget) begin
            @(posedge clk); #1;
            if (toggle) lcd_ready = (cyc % 3 == 0);
            cyc++;
        end
        lcd_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (doneCount == 0) begin
            errors++;
            $display("FAIL wait_done: no done after %0d cycles, required done", budget);
        end
    endtask

    task automatic build_exp(input logic [1:0] sel, input logic [3:0] l0, input logic [3:0] l1);
        expQ.delete();
        for (int ln = 0; ln < 2; ln++) begin
            expQ.push_back({1'b1, ln == 0 ? 8'h80 : 8'hC0});
            for (int i = 0; i < 16; i++) begin
                logic [7:0] b;
                case (sel)
                    2'd0:    b = romByte(ln == 0 ? l0 : l1, 4'(i));
                    2'd1:    b = 8'hA0 + 8'(ln * 16 + i);
                    default: b = 8'h40 + 8'(ln * 16 + i);
                endcase
`ifdef LCD_CURSOR_MARK_EN
                if (sel == 2'd0 && ln == 1 && i == 0) b = 8'h7E;
`endif
                expQ.push_back({1'b0, b});
            end
        end
    endtask

    task automatic check_stream(input string name);
        checks++;
        if (gotQ.size() !== expQ.size()) begin
            errors++;
            $display("FAIL %s_len: got %0d bytes, required %0d", name, gotQ.size(), expQ.size());
        end else begin
            for (int i = 0; i < expQ.size(); i++) begin
                checks++;
                if (gotQ[i] !== expQ[i]) begin
                    errors++;
                    $display("FAIL %s[%0d]: got %h, required %h", name, i, gotQ[i], expQ[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; page_sel = 2'd0;
        menu_line0 = 4'd0; menu_line1 = 4'd0; lcd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ram_sel, ram_menu, ram_add, lcd_valid, lcd_is_cmd, lcd_data, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b busy=%b data=%h add=%h, required all 0",
                     lcd_valid, busy, lcd_data, ram_add);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || lcd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b valid=%b, required 0 0", busy, lcd_valid);
        end
    endtask

    task automatic test_local_page();
        clear_obs();
        do_start(2'd2);
        wait_done(300, 1'b0);
        build_exp(2'd2, 4'd0, 4'd0);
        check_stream("local");
        checks++;
        if (busyCycles !== 99) begin
            errors++;
            $display("FAIL local_busy_cycles: got %0d, required 99", busyCycles);
        end
        checks++;
        if (doneCount !== 1) begin
            errors++;
            $display("FAIL local_done_count: got %0d, required 1", doneCount);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL local_busy_after: got %b, required 0", busy);
        end
        if (gotQ.size() == 34) begin
            checks++;
            if (gotQ[1] !== 9'h040 || gotQ[17] !== 9'h180 + 9'h040 || gotQ[33] !== 9'h05F) begin
                errors++;
                $display("FAIL local_literals: got %h %h %h, required 040 1c0 05f",
                         gotQ[1], gotQ[17], gotQ[33]);
            end
        end
    endtask

    task automatic test_menu_page();
        logic [8:0] mark;
`ifdef LCD_CURSOR_MARK_EN
        mark = 9'h07E;
`else
        mark = 9'h0FE;
`endif
        clear_obs();
        menu_line0 = 4'd0;
        menu_line1 = 4'd8;
        do_start(2'd0);
        wait_done(300, 1'b0);
        build_exp(2'd0, 4'd0, 4'd8);
        check_stream("menu");
        checks++;
        if (add4Errs !== 0) begin
            errors++;
            $display("FAIL menu_add_bit4: got %0d cycles with bit4 set, required 0", add4Errs);
        end
        if (gotQ.size() == 34) begin
            checks++;
            if (gotQ[1] !== 9'h04D || gotQ[18] !== mark || gotQ[19] !== 9'h059) begin
                errors++;
                $display("FAIL menu_literals: got %h %h %h, required 04d %h 059",
                         gotQ[1], gotQ[18], gotQ[19], mark);
            end
        end
    endtask

    task automatic test_ready_toggle();
        clear_obs();
        do_start(2'd2);
        wait_done(1000, 1'b1);
        build_exp(2'd2, 4'd0, 4'd0);
        check_stream("toggle");
        checks++;
        if (stallErrs !== 0) begin
            errors++;
            $display("FAIL toggle_stall_stable: got %0d changes while stalled, required 0", stallErrs);
        end
        checks++;
        if (doneCount !== 1) begin
            errors++;
            $display("FAIL toggle_done_count: got %0d, required 1", doneCount);
        end
    endtask

    task automatic test_ignored_starts();
        clear_obs();
        do_start(2'd3);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || gotQ.size() !== 0) begin
            errors++;
            $display("FAIL rsvd_start: got busy=%b bytes=%0d, required 0 0", busy, gotQ.size());
        end
        clear_obs();
        menu_line0 = 4'd0;
        menu_line1 = 4'd8;
        do_start(2'd1);
        for (int c = 0; c < 90; c++) begin
            @(posedge clk); #1;
            start = (c == 10 || c == 40 || c == 70);
            page_sel   = (c < 30) ? 2'd2 : 2'd0;
            menu_line0 = 4'(c);
            menu_line1 = 4'(c + 3);
        end
        start = 1'b0;
        wait_done(200, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        build_exp(2'd1, 4'd0, 4'd0);
        check_stream("ignored");
        checks++;
        if (doneCount !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_single_done: got done=%0d busy=%b, required 1 0", doneCount, busy);
        end
    endtask

    task automatic test_reset_mid_page();
        int cyc = 0;
        clear_obs();
        do_start(2'd2);
        while (gotQ.size() < 22 && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (gotQ.size() !== 22) begin
            errors++;
            $display("FAIL midrst_reach: got %0d bytes, required 22", gotQ.size());
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({ram_sel, ram_menu, ram_add, lcd_valid, lcd_is_cmd, lcd_data, busy, done} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: got valid=%b busy=%b data=%h, required all 0",
                     lcd_valid, busy, lcd_data);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (doneCount !== 0) begin
            errors++;
            $display("FAIL midrst_no_done: got %0d, required 0", doneCount);
        end
        clear_obs();
        do_start(2'd2);
        wait_done(300, 1'b0);
        build_exp(2'd2, 4'd0, 4'd0);
        check_stream("midrst_restart");
    endtask

    initial begin
        test_reset();
        test_local_page();
        test_menu_page();
        test_ready_toggle();
        test_ignored_starts();
        test_reset_mid_page();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
